// File: rtl/divisor_secuencial.sv
// Sequential restoring unsigned divider: collects dividend and divisor over
// independent valid/ack channels, produces one quotient bit per clock, holds the result until ListoS.
module divisor_secuencial #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] dividendo,
   input  logic             validoA,
   output logic             ListoA,
   input  logic [WIDTH-1:0] divisor,
   input  logic             validoB,
   output logic             ListoB,
   input  logic             ListoS,
   output logic [WIDTH-1:0] cociente,
   output logic [WIDTH-1:0] residuo,
   output logic             errorDiv,
   output logic             divisionLista
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDE,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic             r_held_a;
   logic             r_held_b;
   logic             r_listo_a;
   logic             r_listo_b;
   logic             r_lista;
   logic             r_error;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_cociente;
   logic [WIDTH-1:0] r_residuo;
   logic [CNT_W-1:0] r_cnt;

   logic             w_cap_a;
   logic             w_cap_b;
   logic             w_start;
   logic             w_last;
   logic             w_div_zero;
   logic             w_ge;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quo_next;

   assign w_cap_a    = (r_state == S_IDLE) && validoA && !r_held_a;
   assign w_cap_b    = (r_state == S_IDLE) && validoB && !r_held_b;
   assign w_start    = (r_state == S_IDLE) && (r_held_a || w_cap_a) && (r_held_b || w_cap_b);
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_div_zero = (r_div == '0);

   // One restoring step: the shifted remainder needs WIDTH+1 bits so the compare never wraps.
   assign w_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_ge       = (w_shift >= {1'b0, r_div});
   assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_div}) : w_shift[WIDTH-1:0];
   assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      // NOTE: default first so every path assigns w_state_next and no latch is inferred.
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_state_next = S_DIVIDE;
         S_DIVIDE: if (w_div_zero || w_last) w_state_next = S_DONE;
         S_DONE:   if (r_lista && ListoS) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         r_held_a   <= 1'b0;
         r_held_b   <= 1'b0;
         r_listo_a  <= 1'b0;
         r_listo_b  <= 1'b0;
         r_lista    <= 1'b0;
         r_error    <= 1'b0;
         r_quo      <= '0;
         r_div      <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_cociente <= '0;
         r_residuo  <= '0;
      end else begin
         r_listo_a <= w_cap_a;
         r_listo_b <= w_cap_b;
         case (r_state)
            S_IDLE: begin
               if (w_cap_a) begin
                  r_held_a <= 1'b1;
                  r_quo    <= dividendo;
               end
               if (w_cap_b) begin
                  r_held_b <= 1'b1;
                  r_div    <= divisor;
               end
               if (w_start) begin
                  r_cnt <= '0;
                  r_rem <= '0;
               end
            end
            S_DIVIDE: begin
               if (w_div_zero) begin
                  // r_quo still holds the untouched dividend here.
                  r_cociente <= '1;
                  r_residuo  <= r_quo;
                  r_error    <= 1'b1;
               end else begin
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_cociente <= w_quo_next;
                     r_residuo  <= w_rem_next;
                     r_error    <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               if (!r_lista) begin
                  r_lista <= 1'b1;
               end else if (ListoS) begin
                  r_lista  <= 1'b0;
                  r_held_a <= 1'b0;
                  r_held_b <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ListoA        = r_listo_a;
   assign ListoB        = r_listo_b;
   assign cociente      = r_cociente;
   assign residuo       = r_residuo;
   assign errorDiv      = r_error;
   assign divisionLista = r_lista;

endmodule
